// File: rtl/amstrad_mem_pkg.sv
// Shared types for the SDRAM slot arbiter: requester indices, FSM states, default widths.
package amstrad_mem_pkg;

  localparam int unsigned ADDR_W_DEF = 23;
  localparam int unsigned NUM_REQ    = 4;

  // Requester index into the request / grant vectors
  typedef enum logic [1:0] {
    REQ_BOOT = 2'd0,
    REQ_CPU  = 2'd1,
    REQ_VID  = 2'd2,
    REQ_TAPE = 2'd3
  } req_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_prio_select.sv
// Combinational priority pick of one SDRAM requester, returned one-hot.
module mem_prio_select
  import amstrad_mem_pkg::*;
(
  input  logic               boot_mode_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               starved_i,
  output logic [NUM_REQ-1:0] gnt_c_o
);

  // Boot mode admits only boot; otherwise video first, tape jumps CPU when starved
  always_comb begin
    gnt_c_o = '0;
    if (boot_mode_i) begin
      gnt_c_o[REQ_BOOT] = req_i[REQ_BOOT];
    end else if (req_i[REQ_VID]) begin
      gnt_c_o[REQ_VID] = 1'b1;
    end else if (starved_i && req_i[REQ_TAPE]) begin
      gnt_c_o[REQ_TAPE] = 1'b1;
    end else if (req_i[REQ_CPU]) begin
      gnt_c_o[REQ_CPU] = 1'b1;
    end else if (req_i[REQ_TAPE]) begin
      gnt_c_o[REQ_TAPE] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_slot_arbiter.sv
// Request/acknowledge scheduler sharing one SDRAM port between boot, CPU, video and tape.
module mem_slot_arbiter
  import amstrad_mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              clkref,
  input  logic              boot_mode,
  input  logic              boot_req,
  input  logic [ADDR_W-1:0] boot_addr,
  input  logic [1:0]        boot_bank,
  input  logic [7:0]        boot_din,
  output logic              boot_ack,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [1:0]        cpu_bank,
  input  logic [7:0]        cpu_din,
  output logic [7:0]        cpu_dout,
  output logic              cpu_ack,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [15:0]       vid_dout,
  output logic              vid_ack,
  input  logic              tape_req,
  input  logic              tape_we,
  input  logic [ADDR_W-1:0] tape_addr,
  input  logic [7:0]        tape_din,
  output logic [7:0]        tape_dout,
  output logic              tape_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic              mem_wide,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [1:0]        mem_bank,
  output logic [7:0]        mem_din,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              timeout_err
);

  localparam int unsigned SC_W = $clog2(STARVE_MAX + 1);
  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

  arb_state_e         state_q;
  logic [NUM_REQ-1:0] win_q;
  logic [SC_W-1:0]    starve_q;
  logic [WD_W-1:0]    wd_q;
  logic               withdrawn_q;

  logic               boot_ack_q, cpu_ack_q, vid_ack_q, tape_ack_q;
  logic [7:0]         cpu_dout_q, tape_dout_q;
  logic [15:0]        vid_dout_q;
  logic               mem_req_q, mem_we_q, mem_wide_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [1:0]         mem_bank_q;
  logic [7:0]         mem_din_q;
  logic               timeout_err_q;

  logic [NUM_REQ-1:0] req_vec;
  logic [NUM_REQ-1:0] gnt;
  logic               starved;
  logic               withdrawn_c;

  assign req_vec     = {tape_req, vid_req, cpu_req, boot_req};
  assign starved     = (starve_q >= SC_W'(STARVE_MAX));
  // Sticky once the winner drops its request at any point while the access is in flight
  assign withdrawn_c = withdrawn_q | (|(win_q & ~req_vec));

  mem_prio_select u_prio (
    .boot_mode_i (boot_mode),
    .req_i       (req_vec),
    .starved_i   (starved),
    .gnt_c_o     (gnt)
  );

  // Slot FSM: grant on clkref, wait for completion or watchdog, then route data and ack
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q       <= IDLE;
      win_q         <= '0;
      starve_q      <= '0;
      wd_q          <= '0;
      withdrawn_q   <= 1'b0;
      boot_ack_q    <= 1'b0;
      cpu_ack_q     <= 1'b0;
      vid_ack_q     <= 1'b0;
      tape_ack_q    <= 1'b0;
      cpu_dout_q    <= '0;
      tape_dout_q   <= '0;
      vid_dout_q    <= '0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_wide_q    <= 1'b0;
      mem_addr_q    <= '0;
      mem_bank_q    <= '0;
      mem_din_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      boot_ack_q <= 1'b0;
      cpu_ack_q  <= 1'b0;
      vid_ack_q  <= 1'b0;
      tape_ack_q <= 1'b0;
      mem_req_q  <= 1'b0;
      if (!tape_req) starve_q <= '0;

      unique case (state_q)
        IDLE: begin
          if (clkref && (|gnt)) begin
            state_q     <= BUSY;
            win_q       <= gnt;
            wd_q        <= '0;
            withdrawn_q <= 1'b0;
            mem_req_q   <= 1'b1;
            if (gnt[REQ_TAPE] || !tape_req) begin
              starve_q <= '0;
            end else if (!starved) begin
              starve_q <= starve_q + SC_W'(1);
            end
            if (gnt[REQ_VID]) begin
              mem_we_q   <= 1'b0;
              mem_wide_q <= 1'b1;
              mem_addr_q <= vid_addr & ~ADDR_W'(1);
              mem_bank_q <= 2'b00;
              mem_din_q  <= 8'h00;
            end else if (gnt[REQ_TAPE]) begin
              mem_we_q   <= tape_we;
              mem_wide_q <= 1'b0;
              mem_addr_q <= tape_addr;
              mem_bank_q <= 2'b00;
              mem_din_q  <= tape_we ? tape_din : 8'h00;
            end else if (gnt[REQ_CPU]) begin
              mem_we_q   <= cpu_we;
              mem_wide_q <= 1'b0;
              mem_addr_q <= cpu_addr;
              mem_bank_q <= cpu_bank;
              mem_din_q  <= cpu_we ? cpu_din : 8'h00;
            end else begin
              mem_we_q   <= 1'b1;
              mem_wide_q <= 1'b0;
              mem_addr_q <= boot_addr;
              mem_bank_q <= boot_bank;
              mem_din_q  <= boot_din;
            end
          end
        end
        BUSY: begin
          if (mem_ack) begin
            state_q    <= DONE;
            boot_ack_q <= win_q[REQ_BOOT] & ~withdrawn_c;
            cpu_ack_q  <= win_q[REQ_CPU]  & ~withdrawn_c;
            vid_ack_q  <= win_q[REQ_VID]  & ~withdrawn_c;
            tape_ack_q <= win_q[REQ_TAPE] & ~withdrawn_c;
            if (win_q[REQ_CPU])  cpu_dout_q  <= mem_rdata[7:0];
            if (win_q[REQ_TAPE]) tape_dout_q <= mem_rdata[7:0];
            if (win_q[REQ_VID])  vid_dout_q  <= mem_rdata;
          end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
            state_q       <= IDLE;
            timeout_err_q <= 1'b1;
          end else begin
            wd_q        <= wd_q + WD_W'(1);
            withdrawn_q <= withdrawn_c;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign boot_ack    = boot_ack_q;
  assign cpu_ack     = cpu_ack_q;
  assign vid_ack     = vid_ack_q;
  assign tape_ack    = tape_ack_q;
  assign cpu_dout    = cpu_dout_q;
  assign tape_dout   = tape_dout_q;
  assign vid_dout    = vid_dout_q;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_wide    = mem_wide_q;
  assign mem_addr    = mem_addr_q;
  assign mem_bank    = mem_bank_q;
  assign mem_din     = mem_din_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_slot_arbiter.sv
// Directed self-checking bench for mem_slot_arbiter with a small SDRAM responder.
module tb_mem_slot_arbiter;

  localparam int unsigned AW = 23;

  logic          clk_sys = 1'b0;
  logic          reset = 1'b1;
  logic          clkref = 1'b0;
  logic          boot_mode = 1'b0;
  logic          boot_req = 1'b0;
  logic [AW-1:0] boot_addr = '0;
  logic [1:0]    boot_bank = '0;
  logic [7:0]    boot_din = '0;
  logic          boot_ack;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [1:0]    cpu_bank = '0;
  logic [7:0]    cpu_din = '0;
  logic [7:0]    cpu_dout;
  logic          cpu_ack;
  logic          vid_req = 1'b0;
  logic [AW-1:0] vid_addr = '0;
  logic [15:0]   vid_dout;
  logic          vid_ack;
  logic          tape_req = 1'b0;
  logic          tape_we = 1'b0;
  logic [AW-1:0] tape_addr = '0;
  logic [7:0]    tape_din = '0;
  logic [7:0]    tape_dout;
  logic          tape_ack;
  logic          mem_req, mem_we, mem_wide;
  logic [AW-1:0] mem_addr;
  logic [1:0]    mem_bank;
  logic [7:0]    mem_din;
  logic [15:0]   mem_rdata = '0;
  logic          mem_ack = 1'b0;
  logic          timeout_err;

  mem_slot_arbiter #(.ADDR_W(AW), .STARVE_MAX(4), .TIMEOUT(15)) dut (
    .clk_sys(clk_sys), .reset(reset), .clkref(clkref), .boot_mode(boot_mode),
    .boot_req(boot_req), .boot_addr(boot_addr), .boot_bank(boot_bank), .boot_din(boot_din),
    .boot_ack(boot_ack),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_bank(cpu_bank),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_dout(vid_dout), .vid_ack(vid_ack),
    .tape_req(tape_req), .tape_we(tape_we), .tape_addr(tape_addr), .tape_din(tape_din),
    .tape_dout(tape_dout), .tape_ack(tape_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_wide(mem_wide), .mem_addr(mem_addr),
    .mem_bank(mem_bank), .mem_din(mem_din), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .timeout_err(timeout_err)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int errors = 0;

  // Responder / monitor state, owned by the main initial block through tick()
  int          phase = 7;
  bit          auto_ack = 1'b1;
  int          lat = 1;
  logic [15:0] rd = '0;
  bit          pend = 1'b0;
  int          cnt = 0;
  bit          req_seen = 1'b0;
  logic [3:0]  ack_now = '0;
  int          n_mem_req = 0, n_boot_ack = 0, n_cpu_ack = 0, n_vid_ack = 0, n_tape_ack = 0;
  logic          last_we, last_wide;
  logic [AW-1:0] last_addr;
  logic [1:0]    last_bank;
  logic [7:0]    last_din;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_counts();
    n_mem_req = 0; n_boot_ack = 0; n_cpu_ack = 0; n_vid_ack = 0; n_tape_ack = 0;
  endtask

  // One clock: clkref every 8 cycles, answer mem_req after lat idle cycles, record outputs
  task automatic tick();
    @(posedge clk_sys);
    #1;
    phase   = (phase + 1) % 8;
    clkref  = (phase == 0);
    mem_ack = 1'b0;
    if (pend) begin
      if (cnt == 0) begin
        mem_ack   = 1'b1;
        mem_rdata = rd;
        pend      = 1'b0;
      end else begin
        cnt--;
      end
    end
    req_seen = mem_req;
    if (mem_req) begin
      n_mem_req++;
      last_we = mem_we; last_wide = mem_wide; last_addr = mem_addr;
      last_bank = mem_bank; last_din = mem_din;
      if (auto_ack) begin
        pend = 1'b1;
        cnt  = lat;
      end
    end
    ack_now = {tape_ack, vid_ack, cpu_ack, boot_ack};
    n_boot_ack += int'(boot_ack);
    n_cpu_ack  += int'(cpu_ack);
    n_vid_ack  += int'(vid_ack);
    n_tape_ack += int'(tape_ack);
  endtask

  task automatic wait_req(input int max, output int n);
    n = 0;
    do begin tick(); n++; end while (!req_seen && n < max);
  endtask

  task automatic wait_ack(input int which, input int max, output int n);
    n = 0;
    do begin tick(); n++; end while (!ack_now[which] && n < max);
  endtask

  initial begin
    int n;
    logic [AW-1:0] exp_addr;

    // Reset state
    reset = 1'b1;
    repeat (3) tick();
    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_timeout", 32'(timeout_err), 0);
    check("rst_vid_dout", 32'(vid_dout), 0);
    check("rst_acks", 32'({boot_ack, cpu_ack, vid_ack, tape_ack}), 0);
    reset = 1'b0;

    // Boot mode: only boot is served, CPU held off
    clr_counts();
    boot_mode = 1'b1; boot_req = 1'b1; boot_addr = 23'h004000; boot_bank = 2'd1; boot_din = 8'hA5;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 23'h000123;
    lat = 1; rd = 16'hFFFF;
    wait_req(20, n);
    check("boot_req_seen", 32'(req_seen), 1);
    check("boot_we", 32'(last_we), 1);
    check("boot_addr", 32'(last_addr), 32'h004000);
    check("boot_din", 32'(last_din), 32'hA5);
    check("boot_bank", 32'(last_bank), 1);
    check("boot_wide", 32'(last_wide), 0);
    wait_ack(0, 10, n);
    check("boot_ack_lat", 32'(n), 3);
    boot_req = 1'b0;
    repeat (20) tick();
    check("boot_cpu_noack", 32'(n_cpu_ack), 0);
    check("boot_one_req", 32'(n_mem_req), 1);
    cpu_req = 1'b0;
    repeat (2) tick();

    // Video beats CPU and tape; boot ignored outside boot mode
    clr_counts();
    boot_mode = 1'b0; boot_req = 1'b1;
    vid_req = 1'b1; vid_addr = 23'h400011; cpu_req = 1'b1; cpu_din = 8'h77; tape_req = 1'b1;
    rd = 16'h1234;
    wait_req(20, n);
    check("vid_wide", 32'(last_wide), 1);
    check("vid_addr", 32'(last_addr), 32'h400010);
    check("vid_bank", 32'(last_bank), 0);
    check("vid_we", 32'(last_we), 0);
    wait_ack(2, 10, n);
    check("vid_ack_lat", 32'(n), 3);
    check("vid_dout", 32'(vid_dout), 32'h1234);
    vid_req = 1'b0; tape_req = 1'b0;
    rd = 16'h55AA;
    wait_req(20, n);
    check("cpu_after_vid_addr", 32'(last_addr), 32'h000123);
    check("cpu_rd_din", 32'(last_din), 0);
    wait_ack(1, 10, n);
    check("cpu_dout_rd", 32'(cpu_dout), 32'hAA);
    cpu_req = 1'b0;
    repeat (10) tick();
    check("boot_ignored", 32'(n_boot_ack), 0);
    boot_req = 1'b0;

    // Anti-starvation: C C C C T C
    clr_counts();
    cpu_we = 1'b1; cpu_addr = 23'h000200; cpu_din = 8'h3C;
    tape_we = 1'b0; tape_addr = 23'h000300; rd = 16'h0099;
    cpu_req = 1'b1; tape_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp_addr = (i == 4) ? 23'h000300 : 23'h000200;
      wait_req(20, n);
      check($sformatf("starve_grant%0d", i), 32'(last_addr), 32'(exp_addr));
      if (i == 0) check("cpu_wr_din", 32'(last_din), 32'h3C);
      wait_ack((i == 4) ? 3 : 1, 10, n);
    end
    cpu_req = 1'b0; tape_req = 1'b0;
    check("starve_tape_acks", 32'(n_tape_ack), 1);
    check("starve_cpu_acks", 32'(n_cpu_ack), 5);
    check("tape_dout", 32'(tape_dout), 32'h99);
    repeat (10) tick();

    // Clkref gating: request raised 3 cycles after clkref
    n = 0;
    while (phase != 3 && n < 10) begin tick(); n++; end
    cpu_we = 1'b0; cpu_req = 1'b1;
    wait_req(20, n);
    check("gate_delay", 32'(n), 6);
    wait_ack(1, 10, n);
    cpu_req = 1'b0;
    repeat (10) tick();

    // Timeout: no mem_ack, abort after 15 busy clocks, then re-grant
    clr_counts();
    auto_ack = 1'b0; rd = 16'h00C3;
    cpu_req = 1'b1;
    wait_req(20, n);
    n = 0;
    do begin tick(); n++; end while (!timeout_err && n < 40);
    check("timeout_clocks", 32'(n), 15);
    check("timeout_noack", 32'(n_cpu_ack), 0);
    auto_ack = 1'b1;
    wait_req(10, n);
    check("timeout_regrant", 32'(n), 1);
    wait_ack(1, 10, n);
    check("timeout_retry_ack", 32'(ack_now[1]), 1);
    check("timeout_retry_dout", 32'(cpu_dout), 32'hC3);
    check("timeout_sticky", 32'(timeout_err), 1);
    cpu_req = 1'b0;
    repeat (4) tick();

    // Withdrawal: op completes, ack suppressed, arbiter keeps working
    clr_counts();
    lat = 3;
    cpu_req = 1'b1;
    wait_req(20, n);
    cpu_req = 1'b0;
    repeat (12) tick();
    check("withdraw_noack", 32'(n_cpu_ack), 0);
    cpu_req = 1'b1;
    wait_req(20, n);
    check("withdraw_next_grant", 32'(req_seen), 1);
    wait_ack(1, 10, n);
    check("withdraw_next_ack", 32'(ack_now[1]), 1);
    cpu_req = 1'b0;
    repeat (4) tick();

    // Reset mid-access drops the transaction
    clr_counts();
    cpu_req = 1'b1;
    wait_req(20, n);
    tick();
    reset = 1'b1;
    tick();
    check("mid_rst_addr", 32'(mem_addr), 0);
    check("mid_rst_we_req", 32'({mem_we, mem_req}), 0);
    check("mid_rst_timeout", 32'(timeout_err), 0);
    check("mid_rst_dout", 32'({cpu_dout, tape_dout, vid_dout}), 0);
    reset = 1'b0; pend = 1'b0; cpu_req = 1'b0;
    repeat (10) tick();
    check("mid_rst_noack", 32'(n_cpu_ack), 0);
    cpu_req = 1'b1;
    wait_req(10, n);
    check("mid_rst_idle_grant", 32'(req_seen), 1);
    wait_ack(1, 10, n);
    cpu_req = 1'b0;
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
